// File: rtl/sp_ram_arbiter.sv
// Front end for a 64x8 single-port RAM: clears every location after reset or on
// command, then shares the RAM round-robin between two masters, one access per cycle.
module sp_ram_arbiter #(
  parameter int                ADDR_W         = 6,
  parameter int                DATA_W         = 8,
  parameter logic [DATA_W-1:0] INIT_VAL       = '0,
  parameter bit                CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_start,
  output logic              busy,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] clr_cnt_next;
  logic              last_gnt;
  logic              last_gnt_next;
  logic              rv0;
  logic              rv1;
  logic              gnt0;
  logic              gnt1;

  // last_gnt resets to 1 so master 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clr_cnt  <= '0;
      last_gnt <= 1'b1;
      rv0      <= 1'b0;
      rv1      <= 1'b0;
    end else begin
      state    <= state_next;
      clr_cnt  <= clr_cnt_next;
      last_gnt <= last_gnt_next;
      rv0      <= gnt0 & ~m0_we;
      rv1      <= gnt1 & ~m1_we;
    end
  end

  always_comb begin
    state_next    = state;
    clr_cnt_next  = clr_cnt;
    last_gnt_next = last_gnt;
    gnt0          = 1'b0;
    gnt1          = 1'b0;
    busy          = 1'b0;
    ram_ce        = 1'b0;
    ram_we        = 1'b0;
    ram_addr      = '0;
    ram_wdata     = '0;
    case (state)
      ST_CLEAR: begin
        busy         = 1'b1;
        ram_ce       = 1'b1;
        ram_we       = 1'b1;
        ram_addr     = clr_cnt;
        ram_wdata    = INIT_VAL;
        clr_cnt_next = clr_cnt + 1'b1;
        if (clr_cnt == {ADDR_W{1'b1}}) begin
          state_next = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (clear_start) begin
          state_next = ST_CLEAR;
        end else begin
          // On a tie the master not served last wins, so grants alternate.
          if (m0_req && (!m1_req || last_gnt)) begin
            gnt0 = 1'b1;
          end else if (m1_req) begin
            gnt1 = 1'b1;
          end
          if (gnt0) begin
            ram_ce        = 1'b1;
            ram_we        = m0_we;
            ram_addr      = m0_addr;
            ram_wdata     = m0_wdata;
            last_gnt_next = 1'b0;
          end else if (gnt1) begin
            ram_ce        = 1'b1;
            ram_we        = m1_we;
            ram_addr      = m1_addr;
            ram_wdata     = m1_wdata;
            last_gnt_next = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign m0_ack    = gnt0;
  assign m1_ack    = gnt1;
  assign m0_rvalid = rv0;
  assign m1_rvalid = rv1;
  assign m0_rdata  = ram_rdata;
  assign m1_rdata  = ram_rdata;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Bench for sp_ram_arbiter: a clearing instance and a no-clear instance share the
// master inputs, each driving its own RAM model.
module tb_sp_ram_arbiter;

  localparam int         ADDR_W   = 6;
  localparam int         DATA_W   = 8;
  localparam int         DEPTH    = 64;
  localparam logic [7:0] INIT_VAL = 8'h00;

  logic              clk;
  logic              rst_n;
  logic              clear_start;
  logic              m0_req, m0_we, m1_req, m1_we;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;

  logic              busy, m0_ack, m0_rvalid, m1_ack, m1_rvalid, ram_ce, ram_we;
  logic [DATA_W-1:0] m0_rdata, m1_rdata, ram_wdata, ram_rdata;
  logic [ADDR_W-1:0] ram_addr;

  logic              busy_nc, m0_ack_nc, m0_rvalid_nc, m1_ack_nc, m1_rvalid_nc, ram_ce_nc, ram_we_nc;
  logic [DATA_W-1:0] m0_rdata_nc, m1_rdata_nc, ram_wdata_nc, ram_rdata_nc;
  logic [ADDR_W-1:0] ram_addr_nc;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] mem_nc [DEPTH];
  logic [ADDR_W-1:0] raddr_nc;

  logic [DATA_W-1:0] model_mem [DEPTH];
  bit                model_last;
  int                tests_run;
  int                tests_failed;

  sp_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INIT_VAL(INIT_VAL), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .clear_start(clear_start), .busy(busy),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  sp_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INIT_VAL(INIT_VAL), .CLEAR_ON_RESET(1'b0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .clear_start(clear_start), .busy(busy_nc),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack_nc), .m0_rvalid(m0_rvalid_nc), .m0_rdata(m0_rdata_nc),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack_nc), .m1_rvalid(m1_rvalid_nc), .m1_rdata(m1_rdata_nc),
    .ram_ce(ram_ce_nc), .ram_we(ram_we_nc), .ram_addr(ram_addr_nc), .ram_wdata(ram_wdata_nc),
    .ram_rdata(ram_rdata_nc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAMs with a registered read address.
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      raddr <= ram_addr;
    end
    if (ram_ce_nc) begin
      if (ram_we_nc) mem_nc[ram_addr_nc] <= ram_wdata_nc;
      raddr_nc <= ram_addr_nc;
    end
  end
  assign ram_rdata    = mem[raddr];
  assign ram_rdata_nc = mem_nc[raddr_nc];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear_start = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic model_cleared();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = INIT_VAL;
    model_last = 1'b1;
  endtask

  // Leaves the bench at a negedge where busy is low, or flags a timeout.
  task automatic wait_not_busy(input int limit);
    bit done;
    done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
      else tick();
    end
    tests_run++;
    if (!done) begin
      tests_failed++;
      $display("[TB] FAIL busy_timeout: busy=%b after %0d cycles, required 0", busy, limit);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 6'd63;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b1 || ram_ce !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 6'(i) ||
          ram_wdata !== INIT_VAL || m0_ack !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL reset_clear[%0d]: busy=%b ce=%b we=%b addr=%0d wdata=%h ack=%b, required busy=1 ce=1 we=1 addr=%0d wdata=%h ack=0",
                 i, busy, ram_ce, ram_we, ram_addr, ram_wdata, m0_ack, i, INIT_VAL);
      end
      tick();
    end
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || m0_ack !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_first_ack: busy=%b m0_ack=%b, required busy=0 m0_ack=1", busy, m0_ack);
    end
    tick();
    m0_req = 1'b0;
    @(negedge clk);
    tests_run++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== INIT_VAL) begin
      tests_failed++;
      $display("[TB] FAIL reset_read63: rvalid=%b rdata=%h, required rvalid=1 rdata=%h", m0_rvalid, m0_rdata, INIT_VAL);
    end
    model_cleared();
    model_last = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 6'h05; m0_wdata = 8'hA5;
    @(negedge clk);
    tests_run++;
    if (m0_ack !== 1'b1 || m1_ack !== 1'b0 || ram_we !== 1'b1 || ram_addr !== 6'h05 || ram_wdata !== 8'hA5) begin
      tests_failed++;
      $display("[TB] FAIL wr_ack: m0_ack=%b m1_ack=%b we=%b addr=%h wdata=%h, required 1 0 1 05 a5",
               m0_ack, m1_ack, ram_we, ram_addr, ram_wdata);
    end
    model_mem[5] = 8'hA5;
    tick();
    m0_req = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 6'h05;
    @(negedge clk);
    tests_run++;
    if (m1_ack !== 1'b1 || m0_rvalid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rd_ack: m1_ack=%b m0_rvalid=%b, required m1_ack=1 m0_rvalid=0", m1_ack, m0_rvalid);
    end
    tick();
    m1_req = 1'b0;
    @(negedge clk);
    tests_run++;
    if (m1_rvalid !== 1'b1 || m1_rdata !== model_mem[5] || m0_rvalid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rd_after_wr: m1_rvalid=%b m1_rdata=%h m0_rvalid=%b, required 1 %h 0",
               m1_rvalid, m1_rdata, m0_rvalid, model_mem[5]);
    end
    model_last = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    bit exp0, prev0;
    // m1 writes last so the following tie goes to m0.
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 6'h10; m0_wdata = 8'h3C;
    tick();
    m0_req = 1'b0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 6'h20; m1_wdata = 8'hC3;
    tick();
    model_mem[16] = 8'h3C;
    model_mem[32] = 8'hC3;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 6'h10;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 6'h20;
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i < 6) begin
        exp0 = (i % 2 == 0);
        tests_run++;
        if (m0_ack !== exp0 || m1_ack !== !exp0) begin
          tests_failed++;
          $display("[TB] FAIL b2b_ack[%0d]: m0_ack=%b m1_ack=%b, required %b %b", i, m0_ack, m1_ack, exp0, !exp0);
        end
      end
      if (i > 0) begin
        prev0 = ((i - 1) % 2 == 0);
        tests_run++;
        if (m0_rvalid !== prev0 || m1_rvalid !== !prev0 ||
            (prev0 && m0_rdata !== model_mem[16]) || (!prev0 && m1_rdata !== model_mem[32])) begin
          tests_failed++;
          $display("[TB] FAIL b2b_rvalid[%0d]: rv0=%b rv1=%b rd0=%h rd1=%h, required rv0=%b rv1=%b data=%h",
                   i, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, prev0, !prev0,
                   prev0 ? model_mem[16] : model_mem[32]);
        end
      end
      tick();
      if (i == 5) begin
        m0_req = 1'b0;
        m1_req = 1'b0;
      end
    end
    model_last = 1'b1;
  endtask

  task automatic test_clear_cmd();
    clear_start = 1'b1;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 6'h05;
    @(negedge clk);
    tests_run++;
    if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || ram_ce !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL clr_start: m0_ack=%b m1_ack=%b ce=%b busy=%b, required all 0", m0_ack, m1_ack, ram_ce, busy);
    end
    tick();
    clear_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b1 || m1_ack !== 1'b0 || ram_addr !== 6'(i) || ram_wdata !== INIT_VAL) begin
        tests_failed++;
        $display("[TB] FAIL clr_run[%0d]: busy=%b m1_ack=%b addr=%0d wdata=%h, required 1 0 %0d %h",
                 i, busy, m1_ack, ram_addr, ram_wdata, i, INIT_VAL);
      end
      tick();
    end
    model_cleared();
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || m1_ack !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL clr_done_ack: busy=%b m1_ack=%b, required busy=0 m1_ack=1", busy, m1_ack);
    end
    tick();
    m1_req = 1'b0;
    @(negedge clk);
    tests_run++;
    if (m1_rvalid !== 1'b1 || m1_rdata !== model_mem[5]) begin
      tests_failed++;
      $display("[TB] FAIL clr_read: m1_rvalid=%b m1_rdata=%h, required 1 %h", m1_rvalid, m1_rdata, model_mem[5]);
    end
    model_last = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_clear();
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    rst_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b1 || ram_addr !== 6'd30) begin
      tests_failed++;
      $display("[TB] FAIL mid_clear_pos: busy=%b addr=%0d, required busy=1 addr=30", busy, ram_addr);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b1 || ram_addr !== 6'(i)) begin
        tests_failed++;
        $display("[TB] FAIL mid_clear_restart[%0d]: busy=%b addr=%0d, required busy=1 addr=%0d", i, busy, ram_addr, i);
      end
      tick();
    end
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_clear_end: busy=%b, required 0", busy);
    end
    model_cleared();
    tick();
  endtask

  task automatic test_reset_drops_read();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 6'h10;
    @(negedge clk);
    tests_run++;
    if (m0_ack !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL drop_ack: m0_ack=%b, required 1", m0_ack);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m0_req = 1'b0;
    @(negedge clk);
    tests_run++;
    if (m0_rvalid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL drop_rvalid: m0_rvalid=%b, required 0", m0_rvalid);
    end
    wait_not_busy(70);
    model_cleared();
    tick();
  endtask

  task automatic test_no_clear_reset();
    logic [DATA_W-1:0] exp_rd;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 6'h05;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (busy_nc !== 1'b0 || m1_ack_nc !== 1'b1 || m0_ack_nc !== 1'b0 || ram_ce_nc !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL noclr_ack: busy=%b m1_ack=%b m0_ack=%b ce=%b, required 0 1 0 1",
               busy_nc, m1_ack_nc, m0_ack_nc, ram_ce_nc);
    end
    exp_rd = mem_nc[5];
    tick();
    m1_req = 1'b0;
    @(negedge clk);
    tests_run++;
    if (m1_rvalid_nc !== 1'b1 || m0_rvalid_nc !== 1'b0 || m1_rdata_nc !== exp_rd || m0_rdata_nc !== exp_rd) begin
      tests_failed++;
      $display("[TB] FAIL noclr_read: rv1=%b rv0=%b rd1=%h rd0=%h, required 1 0 %h %h",
               m1_rvalid_nc, m0_rvalid_nc, m1_rdata_nc, m0_rdata_nc, exp_rd, exp_rd);
    end
    wait_not_busy(70);
    model_cleared();
    tick();
  endtask

  task automatic test_random();
    bit                p0, p1, win0, win1, exp_rv0, exp_rv1, nrv0, nrv1;
    logic              w0, w1;
    logic [ADDR_W-1:0] a0, a1;
    logic [DATA_W-1:0] d0, d1, exp_rd0, exp_rd1;
    p0 = 1'b0; p1 = 1'b0; exp_rv0 = 1'b0; exp_rv1 = 1'b0;
    w0 = 1'b0; w1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0; exp_rd0 = '0; exp_rd1 = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (!p0 && $urandom_range(0, 9) < 7) begin
        p0 = 1'b1; w0 = 1'($urandom_range(0, 1));
        a0 = 6'($urandom_range(0, 7)); d0 = 8'($urandom);
      end
      if (!p1 && $urandom_range(0, 9) < 7) begin
        p1 = 1'b1; w1 = 1'($urandom_range(0, 1));
        a1 = 6'($urandom_range(0, 7)); d1 = 8'($urandom);
      end
      m0_req = p0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
      m1_req = p1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
      @(negedge clk);
      // Contended: whoever was not served last goes next.
      win0 = 1'b0; win1 = 1'b0;
      if (p0 && p1) begin
        if (model_last) win0 = 1'b1;
        else            win1 = 1'b1;
      end else begin
        win0 = p0;
        win1 = p1;
      end
      tests_run++;
      if (m0_ack !== win0 || m1_ack !== win1 || ram_ce !== (win0 | win1) ||
          (win0 && (ram_we !== w0 || ram_addr !== a0 || (w0 && ram_wdata !== d0))) ||
          (win1 && (ram_we !== w1 || ram_addr !== a1 || (w1 && ram_wdata !== d1))) ||
          (!win0 && !win1 && (ram_addr !== '0 || ram_we !== 1'b0))) begin
        tests_failed++;
        $display("[TB] FAIL rnd_grant[%0d]: ack0=%b ack1=%b ce=%b we=%b addr=%0d wdata=%h, required ack0=%b ack1=%b",
                 cyc, m0_ack, m1_ack, ram_ce, ram_we, ram_addr, ram_wdata, win0, win1);
      end
      tests_run++;
      if (m0_rvalid !== exp_rv0 || m1_rvalid !== exp_rv1 ||
          (exp_rv0 && m0_rdata !== exp_rd0) || (exp_rv1 && m1_rdata !== exp_rd1)) begin
        tests_failed++;
        $display("[TB] FAIL rnd_read[%0d]: rv0=%b rv1=%b rd0=%h rd1=%h, required rv0=%b rv1=%b rd0=%h rd1=%h",
                 cyc, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, exp_rv0, exp_rv1, exp_rd0, exp_rd1);
      end
      nrv0 = 1'b0; nrv1 = 1'b0;
      if (win0) begin
        if (w0) model_mem[a0] = d0;
        else begin nrv0 = 1'b1; exp_rd0 = model_mem[a0]; end
        model_last = 1'b0;
        p0 = 1'b0;
      end
      if (win1) begin
        if (w1) model_mem[a1] = d1;
        else begin nrv1 = 1'b1; exp_rd1 = model_mem[a1]; end
        model_last = 1'b1;
        p1 = 1'b0;
      end
      exp_rv0 = nrv0;
      exp_rv1 = nrv1;
      tick();
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    @(negedge clk);
    tests_run++;
    if (m0_rvalid !== exp_rv0 || m1_rvalid !== exp_rv1 ||
        (exp_rv0 && m0_rdata !== exp_rd0) || (exp_rv1 && m1_rdata !== exp_rd1)) begin
      tests_failed++;
      $display("[TB] FAIL rnd_drain: rv0=%b rv1=%b rd0=%h rd1=%h, required rv0=%b rv1=%b rd0=%h rd1=%h",
               m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, exp_rv0, exp_rv1, exp_rd0, exp_rd1);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    idle_inputs();
    model_cleared();
    test_reset();
    test_write_read();
    test_back_to_back();
    test_clear_cmd();
    test_reset_mid_clear();
    test_reset_drops_read();
    test_no_clear_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sp_ram_arbiter.md
Name: sp_ram_arbiter

Overview:
Two-requester controller for the 64x8 single-port RAM (ce/we/addr/data_w inputs, registered read address, read data valid the cycle after the access). It clears the whole RAM to a fixed value after reset or on command. It then arbitrates read/write requests from two masters round-robin, one RAM access per cycle. It sits between the RAM instance and its users, e.g. the LCD refresh engine and the host write path.

Parameters:
ADDR_W, 6, RAM address width; depth = 2**ADDR_W.
DATA_W, 8, RAM data width.
INIT_VAL, 8'h00, value written to every location during a clear.
CLEAR_ON_RESET, 1, 1 = run a clear sequence after reset; 0 = go straight to IDLE.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
clear_start  in  1  request a full-RAM clear; sampled only in IDLE.
busy  out  1  high while in CLEAR.
m0_req  in  1  master 0 access request; held until m0_ack.
m0_we  in  1  master 0 access type: 1 = write, 0 = read.
m0_addr  in  ADDR_W  master 0 address.
m0_wdata  in  DATA_W  master 0 write data.
m0_ack  out  1  access accepted this cycle.
m0_rvalid  out  1  read data valid, one cycle after a read ack.
m0_rdata  out  DATA_W  read data; qualified by m0_rvalid.
m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rvalid, m1_rdata: same as master 0, for master 1.
ram_ce  out  1  RAM chip enable.
ram_we  out  1  RAM write enable.
ram_addr  out  ADDR_W  RAM address.
ram_wdata  out  DATA_W  RAM write data.
ram_rdata  in  DATA_W  RAM read data.

Behaviour:
- States: CLEAR and IDLE. Registers: state, clr_cnt[ADDR_W-1:0], last_gnt (1 = master 1 was granted last), rv0, rv1.
- Reset (rst_n=0 at an edge): state <= CLEAR if CLEAR_ON_RESET, else IDLE. clr_cnt <= 0, last_gnt <= 1 (master 0 wins the first tie), rv0 <= 0, rv1 <= 0.
- Reset mid-clear restarts the clear from address 0. Reset drops any read in flight: no rvalid follows.
- Outputs are combinational from state and inputs. RAM outputs are 0 whenever no access is issued (ram_ce=0, ram_we=0, ram_addr=0, ram_wdata=0).
- CLEAR state:
  - busy=1, ram_ce=1, ram_we=1, ram_addr=clr_cnt, ram_wdata=INIT_VAL.
  - Both acks are 0; requests are ignored and stay pending.
  - clr_cnt increments each cycle. When clr_cnt = 2**ADDR_W-1, next state is IDLE and clr_cnt wraps to 0. A clear is exactly 64 cycles.
  - clear_start is ignored in CLEAR.
- IDLE state:
  - busy=0.
  - If clear_start=1: no grant this cycle, next state is CLEAR. clear_start has priority over requests.
  - Otherwise, grant winner: only one req high -> that master. Both high -> master 0 if last_gnt=1, else master 1. Neither -> no access.
  - Winner: mX_ack=1 in the same cycle. ram_ce=1; ram_we, ram_addr, ram_wdata taken from the winner's mX_we, mX_addr, mX_wdata. last_gnt <= winner.
  - Loser keeps req high and is granted on a following cycle. Under continuous contention grants strictly alternate; neither master waits more than 1 cycle.
- Read return: rvX <= (ackX & ~mX_we), so mX_rvalid pulses exactly 1 cycle after a read ack. m0_rdata and m1_rdata both equal ram_rdata; each is meaningful only under its own rvalid. Writes produce no rvalid.
- Throughput: 1 access per cycle. A master may reassert a new request the cycle after its ack and may hold req high for back-to-back grants.
- Ordering and hazards:
  - Read issued the cycle after a write to the same address returns the new data.
  - Write issued the cycle after a read of the same address: the read still returns the old data. The write commits at the end of the rvalid cycle.
- Masters hold addr, we and wdata stable while req=1 and ack=0. Changes in that window are undefined.

Test Plan:
- Reset with CLEAR_ON_RESET=1, m0_req held high -> busy=1 for exactly 64 cycles with ram_addr 0..63 and ram_wdata=8'h00. First m0_ack appears in the cycle busy drops. Reading addr 63 then returns 8'h00.
- m0 writes 8'hA5 @ 6'h05, next cycle m1 reads 6'h05 -> m1_ack on that read cycle, m1_rvalid=1 the following cycle with m1_rdata=8'hA5, m0_rvalid never asserted.
- Both masters hold req for 6 cycles (m0 reads 0x10, m1 reads 0x20) -> ack sequence m0,m1,m0,m1,m0,m1. Each rvalid lags its ack by 1 cycle with the correct data.
- clear_start=1 in the same cycle as m1_req -> no ack that cycle, busy=1 for the next 64 cycles. m1_ack follows on the cycle busy returns to 0.
- rst_n=0 for one edge at clr_cnt=30 -> the clear restarts at ram_addr 0 and runs a full 64 cycles.
- rst_n=0 on the edge right after a read ack -> that read's rvalid never asserts.
- CLEAR_ON_RESET=0, reset released -> busy=0 immediately and m1_req is acked in the first cycle after reset.
